// File: rtl/divide_seq_if.sv
// -----------------------------------------------------------------------------
// divide_seq_if
// Request/result bundle for the sequential 32-bit divider.
//   div_begin  : level request, held by the requester until div_end is seen
//   div_signed : 1 = two's-complement operands, 0 = unsigned
//   div_op1    : dividend
//   div_op2    : divisor
//   quotient   : registered quotient, valid while div_end = 1
//   remainder  : registered remainder, valid while div_end = 1
//   div_end    : result valid, held until div_begin falls
//   div_busy   : divider is iterating
// The master modport is the requester; the slave modport is the divider.
// -----------------------------------------------------------------------------
interface divide_seq_if;
  logic        div_begin;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_end;
  logic        div_busy;

  modport master (
    output div_begin, div_signed, div_op1, div_op2,
    input  quotient, remainder, div_end, div_busy
  );

  modport slave (
    input  div_begin, div_signed, div_op1, div_op2,
    output quotient, remainder, div_end, div_busy
  );
endinterface

// File: rtl/divide_seq.sv
// -----------------------------------------------------------------------------
// divide_seq
// Sequential 32-bit restoring divider, signed or unsigned, one quotient bit
// per clock. Operands are captured once on the request edge, 32 iterations
// follow, and the sign-corrected result is held until the request drops.
//
// Ports
//   clk    : rising-edge clock for all state
//   resetn : synchronous active-low reset
//   bus    : divide_seq_if.slave (request, operands, result, status)
//
// Timing: with the capture edge counted as edge 1, div_end first reads 1
// after edge 33. A zero divisor skips the iterations and reads div_end after
// edge 1 with quotient all ones and the raw dividend as remainder.
// -----------------------------------------------------------------------------
module divide_seq (
  input  logic         clk,
  input  logic         resetn,
  divide_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_count;      // iterations completed so far
  logic [63:0] r_work;       // [63:32] partial remainder, [31:0] quotient bits
  logic [31:0] r_abs1;       // |dividend|
  logic [31:0] r_abs2;       // |divisor|
  logic        r_q_neg;      // negate quotient at the end
  logic        r_r_neg;      // negate remainder at the end
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;

  // ---------------------------------------------------------------------------
  // Capture-side decode: absolute values and result signs
  // ---------------------------------------------------------------------------
  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_div_zero;

  assign w_op1_neg  = bus.div_signed & bus.div_op1[31];
  assign w_op2_neg  = bus.div_signed & bus.div_op2[31];
  assign w_abs1     = w_op1_neg ? (~bus.div_op1 + 32'd1) : bus.div_op1;
  assign w_abs2     = w_op2_neg ? (~bus.div_op2 + 32'd1) : bus.div_op2;
  assign w_div_zero = (bus.div_op2 == 32'd0);

  // ---------------------------------------------------------------------------
  // One restoring step: shift the partial remainder left, bring in the next
  // dividend bit (MSB first), subtract the divisor if it fits.
  // ---------------------------------------------------------------------------
  logic [4:0]  w_bit_idx;
  logic [32:0] w_rem_shift;
  logic [33:0] w_diff;
  logic        w_fits;
  logic [63:0] w_work_nxt;
  logic        w_last;
  logic [31:0] w_q_abs;
  logic [31:0] w_r_abs;
  logic [31:0] w_q_final;
  logic [31:0] w_r_final;

  assign w_bit_idx   = 5'd31 - r_count[4:0];
  assign w_rem_shift = {r_work[63:32], r_abs1[w_bit_idx]};
  // One guard bit above the 33-bit shifted remainder exposes the borrow.
  assign w_diff      = {1'b0, w_rem_shift} - {2'b00, r_abs2};
  assign w_fits      = ~w_diff[33];
  // When the subtraction fits the difference is below |divisor|, so it always
  // fits in 32 bits; when it does not, the shifted remainder is below
  // |divisor| and its bit 32 is zero.
  assign w_work_nxt  = w_fits ? {w_diff[31:0],      r_work[30:0], 1'b1}
                              : {w_rem_shift[31:0], r_work[30:0], 1'b0};
  assign w_last      = (r_count == 6'd31);

  assign w_q_abs   = w_work_nxt[31:0];
  assign w_r_abs   = w_work_nxt[63:32];
  // 0x80000000 / -1 needs no special case: the magnitude quotient is
  // 0x80000000 and negating it wraps back to 0x80000000.
  assign w_q_final = r_q_neg ? (~w_q_abs + 32'd1) : w_q_abs;
  assign w_r_final = r_r_neg ? (~w_r_abs + 32'd1) : w_r_abs;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment ahead of the case keeps every path assigned,
  // so no latch is inferred for w_state_nxt.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.div_begin) begin
          w_state_nxt = w_div_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!bus.div_begin) begin
          w_state_nxt = S_IDLE;          // abort, results untouched
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.div_begin) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count     <= 6'd0;
      r_work      <= 64'd0;
      r_abs1      <= 32'd0;
      r_abs2      <= 32'd0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.div_begin) begin
            if (w_div_zero) begin
              r_quotient  <= 32'hFFFF_FFFF;
              r_remainder <= bus.div_op1;
            end else begin
              r_abs1  <= w_abs1;
              r_abs2  <= w_abs2;
              r_q_neg <= w_op1_neg ^ w_op2_neg;
              r_r_neg <= w_op1_neg;           // remainder follows the dividend
              r_count <= 6'd0;
              r_work  <= 64'd0;
            end
          end
        end
        S_BUSY: begin
          if (bus.div_begin) begin
            r_work  <= w_work_nxt;
            r_count <= r_count + 6'd1;
            if (w_last) begin
              r_quotient  <= w_q_final;
              r_remainder <= w_r_final;
            end
          end
        end
        default: begin
          // S_DONE holds the result until the request drops.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_end   = (r_state == S_DONE);
  assign bus.div_busy  = (r_state == S_BUSY);

endmodule

// File: doc/divide_seq.md
DIVIDE_SEQ -- requirements
Module: divide_seq

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 div_begin  input  1  level request; held high by the requester until div_end is seen.
REQ-005 div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at capture only.
REQ-006 div_op1  input  32  dividend; sampled at capture only.
REQ-007 div_op2  input  32  divisor; sampled at capture only.
REQ-008 quotient  output  32  registered quotient, valid while div_end=1.
REQ-009 remainder  output  32  registered remainder, valid while div_end=1.
REQ-010 div_end  output  1  result valid; stays high until div_begin falls.
REQ-011 div_busy  output  1  high in BUSY state.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-013 IDLE->BUSY on an edge where div_begin=1 and divisor!=0 (the capture edge); SHALL latch |op1|, |op2|, quotient sign, remainder sign, and clear the 6-bit iteration counter and 64-bit working register.
REQ-014 Absolute value SHALL be taken only when div_signed=1 and operand bit 31=1 (~x+1); otherwise the operand is used unchanged.
REQ-015 BUSY SHALL perform one restoring shift-subtract step per cycle: shift working remainder left by 1, bring in next dividend MSB, subtract |op2| when the result is non-negative, shift the quotient bit in.
REQ-016 BUSY->DONE after exactly 32 iterations; div_end SHALL first read 1 after the 33rd rising edge counting the capture edge as the 1st.
REQ-017 On BUSY->DONE, quotient SHALL be negated if quotient sign=1 (op1[31]^op2[31] in signed mode), and remainder SHALL be negated if remainder sign=1 (op1[31] in signed mode); the remainder takes the dividend's sign.
REQ-018 DONE SHALL hold quotient, remainder and div_end=1 while div_begin=1; DONE->IDLE on the first edge with div_begin=0; div_end SHALL read 0 after that edge.
REQ-019 div_begin dropping during BUSY SHALL abort: next edge -> IDLE, div_end stays 0, outputs keep their previous values.
REQ-020 Divisor zero at capture: IDLE->DONE in one edge, quotient=32'hFFFFFFFF, remainder=div_op1 unchanged, for both signed and unsigned.
REQ-021 Signed overflow 32'h80000000 / 32'hFFFFFFFF SHALL give quotient=32'h80000000, remainder=0, with no extra latency.
REQ-022 Operand changes after the capture edge SHALL not affect the result.
REQ-023 div_begin held high after DONE->IDLE is not possible by REQ-018; a new request requires div_begin low for at least one edge.

Reset
REQ-024 resetn=0 on any edge, including mid-BUSY, SHALL force IDLE, counter=0, quotient=0, remainder=0, div_end=0, div_busy=0.
REQ-025 While resetn=0, div_begin SHALL be ignored; capture may occur on the first edge with resetn=1.

Verification
REQ-026 Signed 100 / 7, div_begin held -> after 33 edges quotient=14, remainder=2, div_end=1; stays until div_begin low.
REQ-027 Signed -100 / 7 -> quotient=32'hFFFFFFF2 (-14), remainder=32'hFFFFFFFE (-2); unsigned 32'hFFFFFFFF / 2 -> quotient=32'h7FFFFFFF, remainder=1.
REQ-028 Divide by zero, op1=32'h12345678 -> div_end after 1 edge, quotient=32'hFFFFFFFF, remainder=32'h12345678.
REQ-029 Signed 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0 at edge 33.
REQ-030 resetn low at iteration 10 -> div_end=0, outputs 0; a new request after reset release returns a correct result in 33 edges.
REQ-031 div_begin dropped at iteration 5 -> IDLE next edge, div_end never asserts; the next request completes normally. Random signed and unsigned pairs (10k) SHALL be checked against a reference model.
